// File: rtl/pmodenc_quad_decoder.sv
// PmodENC front end: synchronizes and debounces A/B/BTN/SWT, then decodes full
// quadrature detents into a one-cycle event pulse plus a direction flag.
module pmodenc_quad_decoder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit SIMULATE        = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic PmodENC_A,
    input  logic PmodENC_B,
    input  logic PmodENC_BTN,
    input  logic PmodENC_SWT,
    input  logic err_clr,
    output logic rotary_event,
    output logic rotary_left,
    output logic btn_db,
    output logic swt_db,
    output logic quad_err
);

    localparam int          N_EFF    = SIMULATE ? 4 : DEBOUNCE_CYCLES;
    localparam logic [15:0] CNT_LAST = 16'(N_EFF - 1);
    // Channel order {SWT, BTN, B, A}; A/B rest high because the detent rest state is AB=11.
    localparam logic [3:0]  RST_VAL  = 4'b0011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        R1   = 3'd1,
        R2   = 3'd2,
        R3   = 3'd3,
        L1   = 3'd4,
        L2   = 3'd5,
        L3   = 3'd6,
        WAIT = 3'd7
    } state_t;

    logic [3:0] raw_vec;
    logic [3:0] db_vec;

    assign raw_vec = {PmodENC_SWT, PmodENC_BTN, PmodENC_B, PmodENC_A};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic        sync1_reg;
            logic        sync2_reg;
            logic        stable_reg;
            logic [15:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg  <= RST_VAL[gi];
                    sync2_reg  <= RST_VAL[gi];
                    stable_reg <= RST_VAL[gi];
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg <= raw_vec[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        // Nth consecutive differing cycle: accept the new level.
                        stable_reg <= sync2_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
            end

            assign db_vec[gi] = stable_reg;
        end
    endgenerate

    logic [1:0] ab;
    state_t     state_reg;
    state_t     state_next;
    logic       event_next;
    logic       left_next;
    logic       err_set;
    logic       rotary_event_reg;
    logic       rotary_left_reg;
    logic       quad_err_reg;

    assign ab = {db_vec[0], db_vec[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            rotary_event_reg <= 1'b0;
            rotary_left_reg  <= 1'b0;
            quad_err_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rotary_event_reg <= event_next;
            if (event_next) begin
                rotary_left_reg <= left_next;
            end
            // A new error outranks a simultaneous clear.
            quad_err_reg <= err_set | (quad_err_reg & ~err_clr);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ab == 2'b01)      state_next = R1;
                else if (ab == 2'b10) state_next = L1;
                else if (ab == 2'b00) state_next = WAIT;
            end
            R1: begin
                if (ab == 2'b00)      state_next = R2;
                else if (ab == 2'b11) state_next = IDLE;
                else if (ab == 2'b10) state_next = WAIT;
            end
            R2: begin
                if (ab == 2'b10)      state_next = R3;
                else if (ab == 2'b01) state_next = R1;
                else if (ab == 2'b11) state_next = WAIT;
            end
            R3: begin
                if (ab == 2'b11)      state_next = IDLE;
                else if (ab == 2'b00) state_next = R2;
                else if (ab == 2'b01) state_next = WAIT;
            end
            L1: begin
                if (ab == 2'b00)      state_next = L2;
                else if (ab == 2'b11) state_next = IDLE;
                else if (ab == 2'b01) state_next = WAIT;
            end
            L2: begin
                if (ab == 2'b01)      state_next = L3;
                else if (ab == 2'b10) state_next = L1;
                else if (ab == 2'b11) state_next = WAIT;
            end
            L3: begin
                if (ab == 2'b11)      state_next = IDLE;
                else if (ab == 2'b00) state_next = L2;
                else if (ab == 2'b10) state_next = WAIT;
            end
            default: begin
                if (ab == 2'b11)      state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        event_next = 1'b0;
        left_next  = 1'b0;
        err_set    = (state_next == WAIT) && (state_reg != WAIT);
        if (ab == 2'b11) begin
            if (state_reg == R3) begin
                event_next = 1'b1;
            end else if (state_reg == L3) begin
                event_next = 1'b1;
                left_next  = 1'b1;
            end
        end
    end

    assign rotary_event = rotary_event_reg;
    assign rotary_left  = rotary_left_reg;
    assign quad_err     = quad_err_reg;
    assign btn_db       = db_vec[2];
    assign swt_db       = db_vec[3];

endmodule

// File: tb/tb_pmodenc_quad_decoder.sv
// Directed bench for pmodenc_quad_decoder: a window-based debounce model and a
// gray-code displacement model of the detent decoder are compared every cycle.
module tb_pmodenc_quad_decoder;

    localparam int         MN   = 4;
    localparam logic [3:0] RSTV = 4'b0011;

    logic clk;
    logic reset;
    logic pin_a, pin_b, pin_btn, pin_swt, err_clr;
    logic slow_btn;
    logic rotary_event, rotary_left, btn_db, swt_db, quad_err;
    logic s_event, s_left, s_btn_db, s_swt_db, s_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit cmp_en = 1'b0;

    int ev_cnt = 0;
    int ev_at  = 0;
    bit ev_left = 1'b0;
    int slow_ev_cnt = 0;
    bit slow_seen = 1'b0;

    pmodenc_quad_decoder #(.DEBOUNCE_CYCLES(1000), .SIMULATE(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .PmodENC_A(pin_a), .PmodENC_B(pin_b), .PmodENC_BTN(pin_btn), .PmodENC_SWT(pin_swt),
        .err_clr(err_clr),
        .rotary_event(rotary_event), .rotary_left(rotary_left),
        .btn_db(btn_db), .swt_db(swt_db), .quad_err(quad_err)
    );

    pmodenc_quad_decoder #(.DEBOUNCE_CYCLES(1000), .SIMULATE(1'b0)) u_slow (
        .clk(clk), .reset(reset),
        .PmodENC_A(pin_a), .PmodENC_B(pin_b), .PmodENC_BTN(slow_btn), .PmodENC_SWT(pin_swt),
        .err_clr(err_clr),
        .rotary_event(s_event), .rotary_left(s_left),
        .btn_db(s_btn_db), .swt_db(s_swt_db), .quad_err(s_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int phase(input logic a, input logic b);
        case ({a, b})
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    // Model state: channel order {SWT, BTN, B, A}.
    logic [3:0] m_s1, m_s2, m_db;
    logic [3:0] m_hist [MN];
    int m_d, m_last;
    bit m_wait, m_ev, m_left, m_err;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_s1 = RSTV; m_s2 = RSTV; m_db = RSTV;
                for (int i = 0; i < MN; i++) m_hist[i] = RSTV;
                m_d = 0; m_last = 0; m_wait = 0; m_ev = 0; m_left = 0; m_err = 0;
            end else begin
                bit set;
                int cur;
                int delta;
                set  = 0;
                m_ev = 0;
                cur  = phase(m_db[0], m_db[1]);
                // Net displacement from rest: +4 is a right detent, -4 a left one.
                if (m_wait) begin
                    if (cur == 0) begin
                        m_wait = 0; m_last = 0; m_d = 0;
                    end
                end else begin
                    delta = (cur - m_last + 4) % 4;
                    if (delta == 2) begin
                        set = 1; m_wait = 1; m_d = 0;
                    end else if (delta != 0) begin
                        m_d += (delta == 1) ? 1 : -1;
                        m_last = cur;
                        if (m_d == 4) begin
                            m_ev = 1; m_left = 0; m_d = 0;
                        end else if (m_d == -4) begin
                            m_ev = 1; m_left = 1; m_d = 0;
                        end
                    end
                end
                m_err = set | (m_err & !err_clr);
                for (int i = MN - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = m_s2;
                for (int ch = 0; ch < 4; ch++) begin
                    bit same;
                    same = 1;
                    for (int i = 1; i < MN; i++) if (m_hist[i][ch] != m_hist[0][ch]) same = 0;
                    if (same) m_db[ch] = m_hist[0][ch];
                end
                m_s2 = m_s1;
                m_s1 = {pin_swt, pin_btn, pin_b, pin_a};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cmp_event", 32'(rotary_event), 32'(m_ev));
                check("cmp_left",  32'(rotary_left),  32'(m_left));
                check("cmp_btn",   32'(btn_db),       32'(m_db[2]));
                check("cmp_swt",   32'(swt_db),       32'(m_db[3]));
                check("cmp_err",   32'(quad_err),     32'(m_err));
                if (rotary_event === 1'b1) begin
                    ev_cnt++;
                    ev_at   = cyc;
                    ev_left = rotary_left;
                end
                if (s_btn_db === 1'b1) slow_seen = 1'b1;
                if (s_event === 1'b1) slow_ev_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic [1:0] ab);
        pin_a = ab[1];
        pin_b = ab[0];
    endtask

    initial begin
        logic [1:0] right_seq [4];
        logic [1:0] left_seq [4];
        logic [1:0] prev;
        int e0;
        int edge_c;
        int c0;

        right_seq[0] = 2'b01; right_seq[1] = 2'b00; right_seq[2] = 2'b10; right_seq[3] = 2'b11;
        left_seq[0]  = 2'b10; left_seq[1]  = 2'b00; left_seq[2]  = 2'b01; left_seq[3]  = 2'b11;

        reset = 1'b1; err_clr = 1'b0; slow_btn = 1'b0;
        {pin_a, pin_b, pin_btn, pin_swt} = 4'($urandom);
        tick(1);
        cmp_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {pin_a, pin_b, pin_btn, pin_swt} = 4'($urandom);
            tick(1);
        end
        check("rst_event", 32'(rotary_event), 0);
        check("rst_left",  32'(rotary_left),  0);
        check("rst_btn",   32'(btn_db),       0);
        check("rst_swt",   32'(swt_db),       0);
        check("rst_err",   32'(quad_err),     0);
        reset = 1'b0;
        drive_ab(2'b11); pin_btn = 1'b0; pin_swt = 1'b0;
        tick(100);
        check("idle_no_event", 32'(ev_cnt), 0);
        $display("[%0d] reset + idle: events=%0d", cyc, ev_cnt);

        e0 = ev_cnt;
        edge_c = 0;
        for (int i = 0; i < 4; i++) begin
            drive_ab(right_seq[i]);
            edge_c = cyc;
            tick(10);
        end
        check("right_count", 32'(ev_cnt - e0), 1);
        check("right_latency", 32'(ev_at - edge_c), 7);
        check("right_left", 32'(ev_left), 0);
        $display("[%0d] right detent: events=%0d latency=%0d left=%0d", cyc, ev_cnt - e0, ev_at - edge_c, ev_left);

        e0 = ev_cnt;
        prev = 2'b11;
        for (int i = 0; i < 4; i++) begin
            drive_ab(left_seq[i]); tick(3);
            drive_ab(prev);        tick(3);
            drive_ab(left_seq[i]);
            edge_c = cyc;
            tick(10);
            prev = left_seq[i];
        end
        check("left_count", 32'(ev_cnt - e0), 1);
        check("left_latency", 32'(ev_at - edge_c), 7);
        check("left_left", 32'(ev_left), 1);
        $display("[%0d] left detent with glitches: events=%0d left=%0d", cyc, ev_cnt - e0, ev_left);

        pin_swt = 1'b1;
        tick(10);
        check("swt_high", 32'(swt_db), 1);
        $display("[%0d] switch on: swt_db=%0d", cyc, swt_db);

        e0 = ev_cnt;
        drive_ab(2'b01); tick(10);
        drive_ab(2'b11); tick(10);
        check("backout_event", 32'(ev_cnt - e0), 0);
        check("backout_err", 32'(quad_err), 0);
        drive_ab(2'b00); tick(10);
        check("illegal_err", 32'(quad_err), 1);
        drive_ab(2'b10); tick(10);
        drive_ab(2'b11); tick(10);
        check("wait_no_event", 32'(ev_cnt - e0), 0);
        $display("[%0d] back-out + illegal: events=%0d quad_err=%0d", cyc, ev_cnt - e0, quad_err);

        check("err_still_set", 32'(quad_err), 1);
        drive_ab(2'b00);
        tick(6);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("err_set_wins", 32'(quad_err), 1);
        drive_ab(2'b11); tick(10);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("err_clr_alone", 32'(quad_err), 0);
        $display("[%0d] error clear: quad_err=%0d", cyc, quad_err);

        e0 = ev_cnt;
        drive_ab(2'b01); tick(10);
        drive_ab(2'b00); tick(10);
        reset = 1'b1; tick(2); reset = 1'b0;
        tick(10);
        drive_ab(2'b10); tick(10);
        drive_ab(2'b11); tick(10);
        check("reset_mid_no_event", 32'(ev_cnt - e0), 0);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        $display("[%0d] reset mid-detent: events=%0d", cyc, ev_cnt - e0);

        pin_btn = 1'b1; tick(3); pin_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("btn_short", 32'(btn_db), 0);
        end
        pin_btn = 1'b1;
        c0 = cyc;
        tick(4);
        pin_btn = 1'b0;
        tick(1);
        check("btn_before", 32'(btn_db), 0);
        tick(1);
        check("btn_rise", 32'(btn_db), 1);
        check("btn_rise_cycle", 32'(cyc - c0), 6);
        tick(10);
        $display("[%0d] button pulses: btn_db=%0d", cyc, btn_db);

        slow_seen = 1'b0;
        slow_btn = 1'b1; tick(999); slow_btn = 1'b0;
        tick(1100);
        check("slow_glitch", 32'(slow_seen), 0);
        slow_btn = 1'b1;
        tick(1001);
        check("slow_before", 32'(s_btn_db), 0);
        tick(1);
        check("slow_rise", 32'(s_btn_db), 1);
        check("slow_no_event", 32'(slow_ev_cnt), 0);
        check("slow_no_err", 32'(s_err), 0);
        $display("[%0d] slow debounce: btn_db=%0d events=%0d", cyc, s_btn_db, slow_ev_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmodenc_quad_decoder.md
# pmodenc_quad_decoder

Front-end conditioning stage for the PmodENC rotary encoder in the ECE 544 peripheral. It synchronizes and debounces the raw A/B quadrature, pushbutton and slide-switch pins, then decodes full detent cycles with a quadrature state machine. Its outputs are a one-cycle `rotary_event` pulse plus a `rotary_left` direction flag, which feed the interrupt flip-flop and rotary-encoder input port of the control PicoBlaze. It also provides debounced button/switch levels and a sticky quadrature-error flag.

## Interface
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required before a debounced output changes; legal range 2..65535.
- `SIMULATE`, 0: when 1, the effective debounce count is 4, regardless of `DEBOUNCE_CYCLES`.

- `clk` in 1: peripheral clock.
- `reset` in 1: synchronous, active-high reset.
- `PmodENC_A` in 1: raw quadrature channel A; asynchronous.
- `PmodENC_B` in 1: raw quadrature channel B; asynchronous.
- `PmodENC_BTN` in 1: raw pushbutton; asynchronous.
- `PmodENC_SWT` in 1: raw slide switch; asynchronous.
- `err_clr` in 1: synchronous clear of `quad_err`.
- `rotary_event` out 1: one-cycle pulse per completed detent.
- `rotary_left` out 1: direction of the last event (1 = left); updated only with `rotary_event`.
- `btn_db` out 1: debounced pushbutton level.
- `swt_db` out 1: debounced switch level.
- `quad_err` out 1: sticky flag, set on an illegal quadrature transition.

## Operation
- **Synchronizer:** a 2-FF synchronizer on each raw input.
  - A and B sync/debounce registers reset to 1, since the detent rest state is AB=11.
  - BTN and SWT sync/debounce registers reset to 0.
- **Debounce:** one 16-bit counter per input, with N = effective debounce count.
  - Each cycle that the synced value differs from the stable value, the counter increments.
  - On the Nth consecutive differing cycle, stable is loaded from synced and the counter returns to 0.
  - Any cycle with synced equal to stable clears the counter.
  - A glitch shorter than N cycles never propagates.
- **Quadrature FSM** on debounced {A,B}. States: IDLE, R1, R2, R3, L1, L2, L3, WAIT. Reset state is IDLE.
  - Right sequence is 11→01→00→10→11. Left sequence is 11→10→00→01→11.
  - IDLE: 01→R1; 10→L1; 00→WAIT with error; 11 stays.
  - R1: 00→R2; 11→IDLE (back-out, no event); 10→WAIT with error.
  - R2: 10→R3; 01→R1; 11→WAIT with error.
  - R3: 11→IDLE, emitting an event with left=0; 00→R2; 01→WAIT with error.
  - L1, L2, L3: mirror of R1..R3 with 01↔10 swapped. L3→IDLE on 11 emits an event with left=1.
  - WAIT: stays until AB=11, then →IDLE with no event.
  - The debounced value is unchanged in any state → the FSM holds.
- **Error flag:**
  - An error transition sets `quad_err`.
  - `err_clr` clears it.
  - If set and clear occur in the same cycle, set wins.
- **Reset mid-sequence:** FSM returns to IDLE, debounce counters clear, and no event is emitted for the partial detent.

## Timing
- All outputs reset to 0.
- `rotary_event` and `rotary_left` are registered together: the event is high for exactly 1 cycle, and `rotary_left` holds its value until the next event.
- Latency from raw pin edge to debounced output: 2 (sync) + N cycles.
- The FSM registers state and event on the edge after the debounced value changes.
  - Final pin edge of a detent → `rotary_event` high is N+3 cycles.
- Minimum spacing between events is 4 debounced transitions, i.e. ≥4N cycles. No event can be lost; there is no queueing.
- `quad_err` rises 1 cycle after the offending debounced transition.
- `quad_err` falls 1 cycle after `err_clr` is sampled high.
- `btn_db` and `swt_db` have no additional register beyond the debounce stable register.

## Test plan
- **Reset:** assert `reset` for 3 cycles with random pins → all outputs 0, FSM in IDLE; hold AB=11 for 100 cycles → no event.
- **Right detent** (SIMULATE=1, N=4): AB steps 11→01→00→10→11, each held 10 cycles → exactly one `rotary_event` pulse, 7 cycles after the final edge, with `rotary_left`=0.
- **Left detent** plus bounce: left sequence with each edge preceded by 3-cycle glitches → one event with `rotary_left`=1 and no extra events; with SIMULATE=0 and a 999-cycle glitch → no change.
- **Back-out:** 11→01→11 → no event, `quad_err`=0; then 11→00 → `quad_err`=1, FSM in WAIT, no event until AB=11.
- **Error clear:** `err_clr` pulsed in the same cycle as a new illegal transition → `quad_err` stays 1; a later `err_clr` alone → 0 on the next cycle.
- **Reset mid-detent and BTN:** reset asserted in R2 → no event when the sequence finishes 10→11; BTN held 1 for 4 cycles (after sync) → `btn_db`=1; BTN held 1 for 3 cycles → `btn_db` unchanged.
